// File: rtl/cl_pcie_perf_pkg.sv
// Shared types for the PCIe performance measurement-run controller.
package cl_pcie_perf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } run_state_e;

    localparam int unsigned WR_DONE_BIT = 0;
    localparam int unsigned RD_DONE_BIT = 1;

endpackage

// File: rtl/perf_phase_timer.sv
// One measurement phase: beat counter, cycle counter, outstanding-response
// tracking (write phase only) and done flag, all saturating.
module perf_phase_timer #(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned OUT_W    = 16,
    parameter bit          USE_RESP = 1'b0
) (
    input  logic             clk_main_a0,
    input  logic             rst_main_n,
    input  logic             arm_i,
    input  logic             en_i,
    input  logic             addr_hs_i,
    input  logic             beat_hs_i,
    input  logic             resp_hs_i,
    input  logic [CNT_W-1:0] target_i,
    output logic [CNT_W-1:0] beat_count_o,
    output logic [CNT_W-1:0] clk_count_o,
    output logic             done_o,
    output logic             done_nxt_o
);

    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0] clk_q, clk_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             started_q, started_d;
    logic             done_q, done_d;
    logic             out_clear;

    always_comb begin
        target_d  = target_q;
        beat_d    = beat_q;
        clk_d     = clk_q;
        out_d     = out_q;
        started_d = started_q;
        done_d    = done_q;
        out_clear = 1'b0;
        if (arm_i) begin
            target_d  = target_i;
            beat_d    = '0;
            clk_d     = '0;
            out_d     = '0;
            started_d = 1'b0;
            done_d    = (target_i == '0);
        end else if (en_i) begin
            started_d = started_q | addr_hs_i;
            if (beat_hs_i && beat_q != '1)
                beat_d = beat_q + 1'b1;
            if (addr_hs_i && !resp_hs_i && out_q != '1)
                out_d = out_q + 1'b1;
            else if (!addr_hs_i && resp_hs_i && out_q != '0)
                out_d = out_q - 1'b1;
            // the completing cycle itself is counted; done shows up one cycle later
            if (started_d && !done_q && clk_q != '1)
                clk_d = clk_q + 1'b1;
            out_clear = !USE_RESP || (out_d == '0);
            if (started_d && beat_d >= target_q && out_clear)
                done_d = 1'b1;
        end
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            target_q  <= '0;
            beat_q    <= '0;
            clk_q     <= '0;
            out_q     <= '0;
            started_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            target_q  <= target_d;
            beat_q    <= beat_d;
            clk_q     <= clk_d;
            out_q     <= out_d;
            started_q <= started_d;
            done_q    <= done_d;
        end
    end

    assign beat_count_o = beat_q;
    assign clk_count_o  = clk_q;
    assign done_o       = done_q;
    assign done_nxt_o   = done_d;

endmodule

// File: rtl/perf_run_ctrl.sv
// Measurement-run controller for dma_pcis benchmark runs.
// Optional idle timeout enabled by defining PERF_RUN_TIMEOUT_EN.
module perf_run_ctrl
    import cl_pcie_perf_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned OUT_W       = 16,
    parameter logic [31:0] TIMEOUT_CYC = 32'd100_000_000
) (
    input  logic             clk_main_a0,
    input  logic             rst_main_n,
    input  logic             cfg_start,
    input  logic             cfg_abort,
    input  logic [CNT_W-1:0] cfg_wr_beats,
    input  logic [CNT_W-1:0] cfg_rd_beats,
    input  logic             mon_awvalid,
    input  logic             mon_awready,
    input  logic             mon_arvalid,
    input  logic             mon_arready,
    input  logic             mon_wvalid,
    input  logic             mon_wready,
    input  logic             mon_bvalid,
    input  logic             mon_bready,
    input  logic             mon_rvalid,
    input  logic             mon_rready,
    output logic             pcis_en,
    output logic             busy,
    output logic [1:0]       rw_done,
    output logic [CNT_W-1:0] wr_clk_count,
    output logic [CNT_W-1:0] rd_clk_count,
    output logic [CNT_W-1:0] wr_beat_count,
    output logic [CNT_W-1:0] rd_beat_count,
    output logic             timeout
);

    run_state_e state_q, state_d;
    logic       active_q;
    logic       aw_hs, ar_hs, w_hs, b_hs, r_hs;
    logic       run_active, arm, en;
    logic       wr_done, rd_done, wr_done_nxt, rd_done_nxt;

    assign aw_hs = mon_awvalid & mon_awready;
    assign ar_hs = mon_arvalid & mon_arready;
    assign w_hs  = mon_wvalid  & mon_wready;
    assign b_hs  = mon_bvalid  & mon_bready;
    assign r_hs  = mon_rvalid  & mon_rready;

    assign run_active = (state_q == ST_ARMED) || (state_q == ST_RUN);
    assign arm        = cfg_start && !cfg_abort && !run_active;
    assign en         = run_active && !cfg_abort;

    perf_phase_timer #(.CNT_W(CNT_W), .OUT_W(OUT_W), .USE_RESP(1'b1)) u_wr (
        .clk_main_a0 (clk_main_a0),
        .rst_main_n  (rst_main_n),
        .arm_i       (arm),
        .en_i        (en),
        .addr_hs_i   (aw_hs),
        .beat_hs_i   (w_hs),
        .resp_hs_i   (b_hs),
        .target_i    (cfg_wr_beats),
        .beat_count_o(wr_beat_count),
        .clk_count_o (wr_clk_count),
        .done_o      (wr_done),
        .done_nxt_o  (wr_done_nxt)
    );

    perf_phase_timer #(.CNT_W(CNT_W), .OUT_W(OUT_W), .USE_RESP(1'b0)) u_rd (
        .clk_main_a0 (clk_main_a0),
        .rst_main_n  (rst_main_n),
        .arm_i       (arm),
        .en_i        (en),
        .addr_hs_i   (ar_hs),
        .beat_hs_i   (r_hs),
        .resp_hs_i   (1'b0),
        .target_i    (cfg_rd_beats),
        .beat_count_o(rd_beat_count),
        .clk_count_o (rd_clk_count),
        .done_o      (rd_done),
        .done_nxt_o  (rd_done_nxt)
    );

`ifdef PERF_RUN_TIMEOUT_EN
    logic [31:0] idle_q, idle_d;
    logic        timeout_q, timeout_d;
`endif

    always_comb begin
        state_d = state_q;
`ifdef PERF_RUN_TIMEOUT_EN
        idle_d    = idle_q;
        timeout_d = timeout_q;
`endif
        if (cfg_abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (cfg_start) begin
                        state_d = ST_ARMED;
`ifdef PERF_RUN_TIMEOUT_EN
                        idle_d    = '0;
                        timeout_d = 1'b0;
`endif
                    end
                end
                ST_ARMED: begin
                    if (aw_hs || ar_hs)
                        state_d = (wr_done_nxt && rd_done_nxt) ? ST_DONE : ST_RUN;
                end
                ST_RUN: begin
                    if (wr_done_nxt && rd_done_nxt)
                        state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
`ifdef PERF_RUN_TIMEOUT_EN
            if (run_active) begin
                if (aw_hs || ar_hs || w_hs || b_hs || r_hs)
                    idle_d = '0;
                else if (idle_q != '1)
                    idle_d = idle_q + 1'b1;
                if (idle_d >= TIMEOUT_CYC) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            state_q  <= ST_IDLE;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= (state_d == ST_ARMED) || (state_d == ST_RUN);
        end
    end

`ifdef PERF_RUN_TIMEOUT_EN
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0 & (TIMEOUT_CYC != '0);
`endif

    assign pcis_en                  = active_q;
    assign busy                     = active_q;
    assign rw_done[WR_DONE_BIT]     = wr_done;
    assign rw_done[RD_DONE_BIT]     = rd_done;

endmodule

// File: tb/tb_perf_run_ctrl.sv
// Directed self-checking bench for perf_run_ctrl (32-bit and 8-bit counter builds).
module tb_perf_run_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_start, cfg_abort;
    logic [31:0] cfg_wr_beats, cfg_rd_beats;
    logic        awv, awr, arv, arr, wv, wr, bv, br, rv, rr;

    logic        pcis_en, busy, timeout;
    logic [1:0]  rw_done;
    logic [31:0] wr_clk, rd_clk, wr_beat, rd_beat;

    logic        p8_en, busy8, timeout8;
    logic [1:0]  rw_done8;
    logic [7:0]  wr_clk8, rd_clk8, wr_beat8, rd_beat8;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    perf_run_ctrl #(.CNT_W(32), .OUT_W(16), .TIMEOUT_CYC(32'd100)) u_dut (
        .clk_main_a0(clk), .rst_main_n(rst_n),
        .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_wr_beats(cfg_wr_beats), .cfg_rd_beats(cfg_rd_beats),
        .mon_awvalid(awv), .mon_awready(awr), .mon_arvalid(arv), .mon_arready(arr),
        .mon_wvalid(wv), .mon_wready(wr), .mon_bvalid(bv), .mon_bready(br),
        .mon_rvalid(rv), .mon_rready(rr),
        .pcis_en(pcis_en), .busy(busy), .rw_done(rw_done),
        .wr_clk_count(wr_clk), .rd_clk_count(rd_clk),
        .wr_beat_count(wr_beat), .rd_beat_count(rd_beat),
        .timeout(timeout)
    );

    perf_run_ctrl #(.CNT_W(8), .OUT_W(16), .TIMEOUT_CYC(32'd100)) u_dut8 (
        .clk_main_a0(clk), .rst_main_n(rst_n),
        .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_wr_beats(cfg_wr_beats[7:0]), .cfg_rd_beats(cfg_rd_beats[7:0]),
        .mon_awvalid(awv), .mon_awready(awr), .mon_arvalid(arv), .mon_arready(arr),
        .mon_wvalid(wv), .mon_wready(wr), .mon_bvalid(bv), .mon_bready(br),
        .mon_rvalid(rv), .mon_rready(rr),
        .pcis_en(p8_en), .busy(busy8), .rw_done(rw_done8),
        .wr_clk_count(wr_clk8), .rd_clk_count(rd_clk8),
        .wr_beat_count(wr_beat8), .rd_beat_count(rd_beat8),
        .timeout(timeout8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // v = {aw, w, b, ar, r}: valid and ready driven together
    task automatic drv(input logic [4:0] v, input int unsigned n);
        {awv, awr} = {2{v[4]}};
        {wv, wr}   = {2{v[3]}};
        {bv, br}   = {2{v[2]}};
        {arv, arr} = {2{v[1]}};
        {rv, rr}   = {2{v[0]}};
        for (int unsigned i = 0; i < n; i++) tick();
        {awv, awr, wv, wr, bv, br, arv, arr, rv, rr} = '0;
    endtask

    task automatic arm(input logic [31:0] wb, input logic [31:0] rb);
        cfg_wr_beats = wb;
        cfg_rd_beats = rb;
        cfg_start    = 1'b1;
        tick();
        cfg_start    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_start = 1'b0; cfg_abort = 1'b0;
        cfg_wr_beats = '0; cfg_rd_beats = '0;
        {awv, awr, wv, wr, bv, br, arv, arr, rv, rr} = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        chk("rst_pcis_en", pcis_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rw_done", rw_done, 0);
        chk("rst_counts", wr_clk | rd_clk | wr_beat | rd_beat, 0);
        chk("rst_timeout", timeout, 0);

        // write-only: 4 x (AW, 4 W, B), 2 idle cycles between bursts
        arm(32'd16, 32'd0);
        chk("wr_arm_pcis_en", pcis_en, 1);
        chk("wr_arm_rw_done", rw_done, 2'b10);
        for (int unsigned b = 0; b < 4; b++) begin
            drv(5'b10000, 1);
            drv(5'b01000, 4);
            if (b == 3) chk("wr_pre_b_rw_done", rw_done, 2'b10);
            drv(5'b00100, 1);
            if (b != 3) drv(5'b00000, 2);
        end
        chk("wr_rw_done", rw_done, 2'b11);
        chk("wr_busy", busy, 0);
        chk("wr_pcis_en", pcis_en, 0);
        chk("wr_beat", wr_beat, 16);
        chk("wr_clk", wr_clk, 30);
        tick();
        chk("wr_frozen_clk", wr_clk, 30);

        // read-only: AR, 2 idle, then 8 beats with rready low every other cycle
        arm(32'd0, 32'd8);
        chk("rd_arm_rw_done", rw_done, 2'b01);
        chk("rd_arm_wr_beat_clear", wr_beat, 0);
        drv(5'b00010, 1);
        drv(5'b00000, 2);
        for (int unsigned i = 0; i < 8; i++) begin
            rv = 1'b1; rr = 1'b0;
            tick();
            rr = 1'b1;
            tick();
        end
        rv = 1'b0; rr = 1'b0;
        chk("rd_rw_done", rw_done, 2'b11);
        chk("rd_beat", rd_beat, 8);
        chk("rd_clk", rd_clk, 19);
        chk("rd_wr_clk", wr_clk, 0);
        chk("rd_busy", busy, 0);

        // concurrent: AW+AR, 4 W with 4 R, AW2+B1 same cycle, 4 W, B2
        arm(32'd8, 32'd4);
        drv(5'b10010, 1);
        drv(5'b01001, 4);
        chk("cc_rd_first", rw_done, 2'b10);
        drv(5'b10100, 1);
        drv(5'b01000, 4);
        chk("cc_b_pending_rw_done", rw_done, 2'b10);
        chk("cc_b_pending_busy", busy, 1);
        drv(5'b00100, 1);
        chk("cc_rw_done", rw_done, 2'b11);
        chk("cc_busy", busy, 0);
        chk("cc_wr_clk", wr_clk, 11);
        chk("cc_rd_clk", rd_clk, 5);
        chk("cc_wr_beat", wr_beat, 8);
        chk("cc_rd_beat", rd_beat, 4);

        // start while running is ignored; abort beats a coincident start
        arm(32'd4, 32'd0);
        drv(5'b10000, 1);
        drv(5'b01000, 2);
        cfg_start = 1'b1;
        drv(5'b01000, 1);
        cfg_start = 1'b0;
        drv(5'b01000, 1);
        chk("ign_start_beat", wr_beat, 4);
        chk("ign_start_clk", wr_clk, 5);
        chk("ign_start_busy", busy, 1);
        cfg_start = 1'b1; cfg_abort = 1'b1;
        tick();
        cfg_start = 1'b0; cfg_abort = 1'b0;
        chk("abort_pcis_en", pcis_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_hold_clk", wr_clk, 5);
        chk("abort_hold_beat", wr_beat, 4);
        chk("abort_rw_done", rw_done, 2'b10);
        tick();
        chk("abort_stays_idle", pcis_en, 0);

        // saturation: 300 W beats against target 255
        arm(32'd255, 32'd0);
        drv(5'b10000, 1);
        drv(5'b01000, 300);
        chk("sat8_beat", wr_beat8, 8'hFF);
        chk("sat8_rw_done", rw_done8, 2'b10);
        chk("sat32_beat", wr_beat, 300);
        drv(5'b00100, 1);
        chk("sat8_done", rw_done8, 2'b11);
        chk("sat8_clk", wr_clk8, 8'hFF);
        chk("sat32_clk", wr_clk, 302);
        chk("sat32_done", rw_done, 2'b11);

`ifdef PERF_RUN_TIMEOUT_EN
        arm(32'd1, 32'd1);
        for (int unsigned i = 0; i < 99; i++) tick();
        chk("to_before", timeout, 0);
        chk("to_before_busy", busy, 1);
        tick();
        chk("to_hit", timeout, 1);
        chk("to_busy", busy, 0);
        chk("to_rw_done", rw_done, 2'b00);
`else
        arm(32'd1, 32'd1);
        for (int unsigned i = 0; i < 120; i++) tick();
        chk("no_to_timeout", timeout, 0);
        chk("no_to_busy", busy, 1);
`endif

        // asynchronous reset mid-run
        drv(5'b10000, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pcis_en", pcis_en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_counts", wr_clk | wr_beat | rw_done, 0);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/perf_run_ctrl.md
# perf_run_ctrl

Measurement-run controller for the PCIe performance CL: sequences one host DMA benchmark run on the dma_pcis AXI4 slave path. An OCL-programmed start arms it, it gates acceptance on the dma_pcis address channels, and it times write and read phases from first address handshake to last completion. It reports rw_done plus cycle and beat counts back to the OCL register file. It sits beside the AXI4 target and snoops its handshakes; it never drives data.

## Interface
- CNT_W, 32: width of cycle and beat counters.
- OUT_W, 16: width of outstanding-write-response counter.
- TIMEOUT_CYC, 32'd100_000_000: idle-cycle limit; used only with PERF_RUN_TIMEOUT_EN.

Ports (reset rst_main_n, asynchronous, active-low; clock clk_main_a0):
- clk_main_a0  in  1  main clock
- rst_main_n  in  1  async active-low reset
- cfg_start  in  1  one-cycle start pulse from OCL
- cfg_abort  in  1  one-cycle abort pulse
- cfg_wr_beats  in  CNT_W  expected W beats this run
- cfg_rd_beats  in  CNT_W  expected R beats this run
- mon_awvalid, mon_awready, mon_arvalid, mon_arready  in  1 each  dma_pcis address handshakes
- mon_wvalid, mon_wready, mon_bvalid, mon_bready, mon_rvalid, mon_rready  in  1 each  data/response handshakes
- pcis_en  out  1  AND-ed externally into awready/arready
- busy  out  1  run in progress
- rw_done  out  2  [0] write phase complete, [1] read phase complete
- wr_clk_count, rd_clk_count  out  CNT_W  phase cycle counts
- wr_beat_count, rd_beat_count  out  CNT_W  observed beats
- timeout  out  1  run hit idle limit (tied 0 without macro)

## Operation
- FSM IDLE -> ARMED -> RUN -> DONE. DONE -> ARMED on cfg_start; any state -> IDLE on cfg_abort.
- IDLE/DONE: pcis_en=0. ARMED/RUN: pcis_en=1.
- cfg_start in IDLE/DONE: clear all counts, rw_done, timeout; latch cfg_wr_beats/cfg_rd_beats; go ARMED. cfg_start in ARMED/RUN ignored.
- Latched beat target 0: corresponding rw_done bit set on the arm cycle.
- ARMED -> RUN on first mon_awvalid&&mon_awready or mon_arvalid&&mon_arready.
- Write phase starts at first AW handshake. wr_clk_count increments each cycle from that cycle through the completing cycle. Completes when wr_beat_count reaches target and outstanding-B count is 0.
- Outstanding-B: +1 per AW handshake, -1 per B handshake; both same cycle: unchanged.
- Read phase: same rule on AR and R handshakes. Completes when rd_beat_count reaches target.
- RUN -> DONE when rw_done==2'b11. Counts frozen in DONE.
- Beats past target still count beat counters; clk counters stop at completion.
- All counters saturate at all-ones; no wrap.
- cfg_abort and cfg_start in the same cycle: abort wins.
- Abort: counts hold, rw_done unchanged, busy=0.

## Timing
- Reset values: state IDLE, pcis_en 0, busy 0, rw_done 0, all counts 0, timeout 0.
- All outputs registered; pcis_en rises the cycle after cfg_start.
- rw_done bit rises the cycle after the completing handshake. busy falls on the same edge that both done bits become 1.
- Asynchronous reset mid-run forces IDLE immediately. Any in-flight AXI traffic is the target's concern.

## Configuration
- PERF_RUN_TIMEOUT_EN defined: an idle counter clears on any handshake and increments otherwise in ARMED/RUN. Reaching TIMEOUT_CYC sets timeout=1 and goes to DONE with rw_done as-is.
- Macro undefined: no idle counter; timeout tied 0. A run waits indefinitely.

## Structure
- cl_pcie_perf_pkg: FSM state enum (IDLE, ARMED, RUN, DONE) and rw_done bit index constants WR_DONE_BIT=0, RD_DONE_BIT=1.
- One sub-module: perf_phase_timer, instantiated twice for the write and read phases. It holds the beat counter, clk counter, done flag and saturation logic. Write instance adds the outstanding-B input.

## Test plan
- Write 16 beats in 4×AW len=3, B each, 2 idle cycles between bursts, rd target 0: rw_done=2'b11, wr_beat_count=16, wr_clk_count = first-AW to last-B cycles inclusive.
- Read 8 beats as 1 AR len=7, rready stalls every other cycle, wr target 0: rd_beat_count=8, rd_clk_count=16 plus AR-to-first-R latency.
- Concurrent writes and reads with same-cycle AW and B handshakes: outstanding count is correct; DONE only after last of B and R.
- cfg_start while RUN: ignored, counts continue. cfg_abort with cfg_start in the same cycle: IDLE, pcis_en=0.
- Counter preset near 2^CNT_W-1 (CNT_W=8 build): beat count holds at 8'hFF.
- With PERF_RUN_TIMEOUT_EN and TIMEOUT_CYC=100: arm, no traffic → timeout=1 at cycle 100, state DONE.
